// File: rtl/alu_sequencer_if.sv
// Handshake and bus bundle between the ALU sequencer, its ALU and its consumer.
// master is the sequencer side; slave is the surrounding environment.
interface alu_sequencer_if #(
    parameter int DATA_W = 6
);
    logic              start;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [7:0]        op_mask;
    logic              busy;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [3:0]        alu_fxn;
    logic [DATA_W-1:0] alu_answer;
    logic              alu_carry;
    logic              alu_oflow;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_fxn;
    logic [DATA_W-1:0] res_answer;
    logic              res_carry;
    logic              res_oflow;
    logic              res_last;
    logic              done;

    modport master (
        input  start, a_in, b_in, op_mask,
        input  alu_answer, alu_carry, alu_oflow,
        input  res_ready,
        output busy, alu_x, alu_y, alu_fxn,
        output res_valid, res_fxn, res_answer,
        output res_carry, res_oflow, res_last, done
    );

    modport slave (
        output start, a_in, b_in, op_mask,
        output alu_answer, alu_carry, alu_oflow,
        output res_ready,
        input  busy, alu_x, alu_y, alu_fxn,
        input  res_valid, res_fxn, res_answer,
        input  res_carry, res_oflow, res_last, done
    );
endinterface

// File: rtl/alu_sequencer.sv
// Runs one ALU operand pair through every function selected in a mask,
// lowest code first, presenting each registered result on a valid/ready port.
module alu_sequencer #(
    parameter int DATA_W = 6
) (
    input logic            clk,
    input logic            reset,
    alu_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [7:0]        mask_q;
    logic [2:0]        k_q;
    logic [7:0]        mask_clr;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign mask_clr = mask_q & ~(8'b1 << k_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_n = (bus.op_mask != 8'd0) ? ISSUE : DONE;
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (bus.res_ready)
                    state_n = (mask_q != 8'd0) ? ISSUE : DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Every output is a flop; status bits are derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q            <= '0;
            b_q            <= '0;
            mask_q         <= '0;
            k_q            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.alu_x      <= '0;
            bus.alu_y      <= '0;
            bus.alu_fxn    <= '0;
            bus.res_valid  <= 1'b0;
            bus.res_fxn    <= '0;
            bus.res_answer <= '0;
            bus.res_carry  <= 1'b0;
            bus.res_oflow  <= 1'b0;
            bus.res_last   <= 1'b0;
        end else begin
            bus.busy      <= (state_n != IDLE);
            bus.done      <= (state_n == DONE);
            bus.res_valid <= (state_n == WAIT);
            unique case (state)
                IDLE: begin
                    if (bus.start && bus.op_mask != 8'd0) begin
                        a_q         <= bus.a_in;
                        b_q         <= bus.b_in;
                        mask_q      <= bus.op_mask;
                        k_q         <= lowest(bus.op_mask);
                        bus.alu_x   <= bus.a_in;
                        bus.alu_y   <= bus.b_in;
                        bus.alu_fxn <= {1'b0, lowest(bus.op_mask)};
                    end
                end
                ISSUE: begin
                    bus.res_answer <= bus.alu_answer;
                    bus.res_carry  <= bus.alu_carry;
                    bus.res_oflow  <= bus.alu_oflow;
                    bus.res_fxn    <= {1'b0, k_q};
                    bus.res_last   <= (mask_clr == 8'd0);
                    mask_q         <= mask_clr;
                end
                WAIT: begin
                    if (bus.res_ready) begin
                        bus.res_last <= 1'b0;
                        if (mask_q != 8'd0) begin
                            k_q         <= lowest(mask_q);
                            bus.alu_x   <= a_q;
                            bus.alu_y   <= b_q;
                            bus.alu_fxn <= {1'b0, lowest(mask_q)};
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU in the loop.
// Expected results are queued at start and checked on each handshake.
module tb_alu_sequencer;

    localparam int D = 6;

    typedef struct packed {
        logic [3:0]   fxn;
        logic [D-1:0] ans;
        logic         c;
        logic         o;
        logic         last;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   n_done;
    exp_t sbq[$];
    logic [D+1:0] alu_r;

    alu_sequencer_if #(.DATA_W(D)) bus ();

    alu_sequencer #(.DATA_W(D)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 0 and, 1 or, 2 xor, 3 not x, 4 x, 5 y, 6 add, 7 sub.
    function automatic logic [D+1:0] alu_ref(
        input logic [D-1:0] x, input logic [D-1:0] y, input logic [3:0] f);
        logic [D:0]   s;
        logic [D-1:0] a;
        logic         c;
        logic         o;
        s = '0; a = '0; c = 1'b0; o = 1'b0;
        case (f)
            4'd0: a = x & y;
            4'd1: a = x | y;
            4'd2: a = x ^ y;
            4'd3: a = ~x;
            4'd4: a = x;
            4'd5: a = y;
            4'd6: begin
                s = {1'b0, x} + {1'b0, y};
                a = s[D-1:0];
                c = s[D];
                o = (x[D-1] == y[D-1]) && (a[D-1] != x[D-1]);
            end
            4'd7: begin
                s = {1'b0, x} + {1'b0, ~y} + (D+1)'(1);
                a = s[D-1:0];
                c = s[D];
                o = (x[D-1] != y[D-1]) && (a[D-1] != x[D-1]);
            end
            default: a = '0;
        endcase
        return {c, o, a};
    endfunction

    always_comb begin
        alu_r         = alu_ref(bus.alu_x, bus.alu_y, bus.alu_fxn);
        bus.alu_answer = alu_r[D-1:0];
        bus.alu_oflow  = alu_r[D];
        bus.alu_carry  = alu_r[D+1];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {bus.busy, bus.alu_x, bus.alu_y, bus.alu_fxn,
                bus.res_valid, bus.res_fxn, bus.res_answer,
                bus.res_carry, bus.res_oflow, bus.res_last, bus.done};
    endfunction

    function automatic logic [31:0] payload();
        return 32'({bus.res_fxn, bus.res_answer, bus.res_carry,
                    bus.res_oflow, bus.res_last,
                    bus.alu_x, bus.alu_y, bus.alu_fxn});
    endfunction

    task automatic push_exp(input int f, input int a, input bit c,
                            input bit o, input bit l);
        exp_t e;
        e.fxn  = 4'(f);
        e.ans  = D'(a);
        e.c    = c;
        e.o    = o;
        e.last = l;
        sbq.push_back(e);
    endtask

    task automatic push_batch(input logic [D-1:0] a, input logic [D-1:0] b,
                              input logic [7:0] m);
        logic [D+1:0] r;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                r = alu_ref(a, b, 4'(k));
                push_exp(k, int'(r[D-1:0]), r[D+1], r[D],
                         (m >> (k + 1)) == 8'd0);
            end
        end
    endtask

    task automatic drive_start(input logic [D-1:0] a, input logic [D-1:0] b,
                               input logic [7:0] m);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.a_in    = a;
        bus.b_in    = b;
        bus.op_mask = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Scoreboard: compare each completed transfer against the queue head.
    always @(negedge clk) begin
        if (!reset && bus.done) n_done++;
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (sbq.size() == 0) begin
                chk("extra_result", 32'(bus.res_fxn), 32'hFFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("res_fxn", 32'(bus.res_fxn), 32'(e.fxn));
                chk("res_answer", 32'(bus.res_answer), 32'(e.ans));
                chk("res_carry", 32'(bus.res_carry), 32'(e.c));
                chk("res_oflow", 32'(bus.res_oflow), 32'(e.o));
                chk("res_last", 32'(bus.res_last), 32'(e.last));
            end
        end
    end

    initial begin
        int d0;
        logic [31:0] snap;
        n_cmp = 0;
        n_bad = 0;
        n_done = 0;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.a_in = 6'd5;
        bus.b_in = 6'd3;
        bus.op_mask = 8'hFF;
        bus.res_ready = 1'b0;

        // Reset held with start asserted
        repeat (2) begin
            @(negedge clk);
            chk("rst_outs", outs(), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_outs", outs(), 32'd0);

        // Add/sub with cycle-exact latency
        bus.res_ready = 1'b1;
        push_exp(6, 8, 1'b0, 1'b0, 1'b0);
        push_exp(7, 2, 1'b1, 1'b0, 1'b1);
        drive_start(6'd5, 6'd3, 8'hC0);
        @(negedge clk);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_valid", 32'(bus.res_valid), 32'd0);
        chk("t1_fxn", 32'(bus.alu_fxn), 32'd6);
        @(negedge clk);
        chk("t2_valid", 32'(bus.res_valid), 32'd1);
        @(negedge clk);
        chk("t3_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("t4_valid", 32'(bus.res_valid), 32'd1);
        chk("t4_last", 32'(bus.res_last), 32'd1);
        @(negedge clk);
        chk("t5_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("t6_done", 32'(bus.done), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);

        // Signed overflow on add
        push_exp(6, 32, 1'b0, 1'b1, 1'b1);
        drive_start(6'd31, 6'd1, 8'h40);
        wait_done(20);

        // Empty mask
        d0 = n_done;
        drive_start(6'd7, 6'd7, 8'h00);
        @(negedge clk);
        chk("empty_done", 32'(bus.done), 32'd1);
        chk("empty_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("empty_done2", 32'(bus.done), 32'd0);
        chk("empty_busy", 32'(bus.busy), 32'd0);
        chk("empty_ndone", 32'(n_done - d0), 32'd1);

        // Start pulsed mid-batch must be ignored
        push_batch(6'd10, 6'd20, 8'h05);
        drive_start(6'd10, 6'd20, 8'h05);
        bus.start = 1'b1;
        bus.a_in = 6'd1;
        bus.b_in = 6'd2;
        bus.op_mask = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(20);
        chk("busy_start_sb", 32'(sbq.size()), 32'd0);

        // Backpressure across a full mask
        bus.res_ready = 1'b0;
        push_batch(6'd13, 6'd50, 8'hFF);
        drive_start(6'd13, 6'd50, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            wait_valid("bp_valid");
            chk("bp_order", 32'(bus.res_fxn), 32'(i));
            snap = payload();
            repeat (4) begin
                @(negedge clk);
                chk("bp_hold", payload(), snap);
                chk("bp_vhold", 32'(bus.res_valid), 32'd1);
            end
            @(posedge clk);
            #1;
            bus.res_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.res_ready = 1'b0;
        end
        wait_done(10);
        chk("bp_sb", 32'(sbq.size()), 32'd0);

        // Reset during the second of three results
        push_batch(6'd9, 6'd4, 8'h0B);
        drive_start(6'd9, 6'd4, 8'h0B);
        wait_valid("mr_valid1");
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        wait_valid("mr_valid2");
        chk("mr_fxn2", 32'(bus.res_fxn), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        repeat (2) @(negedge clk);
        chk("mr_outs", outs(), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.res_ready = 1'b1;
        d0 = n_done;
        repeat (6) @(negedge clk);
        chk("mr_nodone", 32'(n_done - d0), 32'd0);
        chk("mr_novalid", 32'(bus.res_valid), 32'd0);

        push_batch(6'd33, 6'd60, 8'h81);
        drive_start(6'd33, 6'd60, 8'h81);
        wait_done(20);
        chk("final_sb", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
